// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Boot-delay sequencer, prioritised redirects with alignment checking,
// halt/resume with interrupt wake, 2/4-byte step and a fetch handshake.
module pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    NUM_REDIR  = 2,
    parameter int                    BOOT_DELAY = 0,
    parameter int                    ALIGN_C    = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REDIR-1:0]            redir_valid_i,
    input  logic [NUM_REDIR*ADDR_WIDTH-1:0] redir_pc_i,
    input  logic                            stall_i,
    input  logic                            fetch_ready_i,
    input  logic                            step_c_i,
    input  logic                            halt_i,
    input  logic                            resume_i,
    output logic [ADDR_WIDTH-1:0]           pc_o,
    output logic                            pc_valid_o,
    output logic [NUM_REDIR-1:0]            redir_taken_o,
    output logic                            misalign_o,
    output logic                            halted_o
);

    localparam int CH_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Clear the low bits that the instruction granularity cannot address.
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r    = a;
        r[0] = 1'b0;
        if (ALIGN_C == 0) r[1] = 1'b0;
        return r;
    endfunction

    // True when align_addr would drop a set bit.
    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] a);
        return (ALIGN_C == 0) ? (a[1] | a[0]) : a[0];
    endfunction

    function automatic logic [NUM_REDIR-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_REDIR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]            state_q;
    logic [7:0]            boot_cnt_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  pc_valid_q;
    logic [NUM_REDIR-1:0]  redir_taken_q;
    logic                  misalign_q;
    logic                  pend_vld_q;
    logic [ADDR_WIDTH-1:0] pend_pc_q;
    logic [CH_W-1:0]       pend_idx_q;

    logic                  any_redir;
    logic [CH_W-1:0]       sel_idx;
    logic [ADDR_WIDTH-1:0] sel_raw;
    logic                  take_new;
    logic                  cand_vld;
    logic [ADDR_WIDTH-1:0] cand_pc;
    logic [CH_W-1:0]       cand_idx;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Priority encoder: lowest-index valid channel wins.
    always_comb begin
        any_redir = 1'b0;
        sel_idx   = '0;
        sel_raw   = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                any_redir = 1'b1;
                sel_idx   = CH_W'(k);
                sel_raw   = redir_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Boot-time pending merge: a new request replaces the stored one unless
    // the stored one came from a strictly higher-priority channel.
    always_comb begin
        take_new = any_redir && (!pend_vld_q || (sel_idx <= pend_idx_q));
        cand_vld = pend_vld_q || any_redir;
        cand_pc  = take_new ? align_addr(sel_raw) : pend_pc_q;
        cand_idx = take_new ? sel_idx : pend_idx_q;
    end

    assign pc_inc = ((ALIGN_C != 0) && step_c_i) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);

    // Sequencer, PC register and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= 8'(BOOT_DELAY);
            pc_q          <= RESET_ADDR;
            pc_valid_q    <= 1'b0;
            redir_taken_q <= '0;
            misalign_q    <= 1'b0;
            pend_vld_q    <= 1'b0;
        end else begin
            redir_taken_q <= '0;
            misalign_q    <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    if (take_new) misalign_q <= is_misaligned(sel_raw);
                    if (boot_cnt_q == 8'd0) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                        pc_q       <= cand_vld ? cand_pc : RESET_ADDR;
                        if (cand_vld) redir_taken_q <= onehot(cand_idx);
                        pend_vld_q <= 1'b0;
                    end else begin
                        boot_cnt_q <= boot_cnt_q - 8'd1;
                        pend_vld_q <= cand_vld;
                        pend_pc_q  <= cand_pc;
                        pend_idx_q <= cand_idx;
                    end
                end
                ST_RUN: begin
                    if (any_redir) begin
                        pc_q          <= align_addr(sel_raw);
                        redir_taken_q <= onehot(sel_idx);
                        misalign_q    <= is_misaligned(sel_raw);
                    end else if (halt_i) begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end else if (!stall_i && fetch_ready_i) begin
                        pc_q <= pc_q + pc_inc;
                    end
                end
                ST_HALT: begin
                    if (any_redir) begin
                        pc_q          <= align_addr(sel_raw);
                        redir_taken_q <= onehot(sel_idx);
                        misalign_q    <= is_misaligned(sel_raw);
                    end
                    // Channel 0 is the interrupt wake; resume beats halt.
                    if ((any_redir && (sel_idx == '0)) || resume_i) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    boot_cnt_q <= 8'(BOOT_DELAY);
                    pc_valid_q <= 1'b0;
                    pend_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign pc_valid_o    = pc_valid_q;
    assign redir_taken_o = redir_taken_q;
    assign misalign_o    = misalign_q;
    assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: two instances (4-byte and 2-byte granularity)
// share one stimulus set.
module tb_pc_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  redir_valid;
    logic [63:0] redir_pc;
    logic        stall;
    logic        fetch_ready;
    logic        step_c;
    logic        halt;
    logic        resume;

    logic [31:0] pc_a, pc_b;
    logic        vld_a, vld_b;
    logic [1:0]  taken_a, taken_b;
    logic        mis_a, mis_b;
    logic        hlt_a, hlt_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    pc_gen #(.ADDR_WIDTH(32), .RESET_ADDR(32'h100), .NUM_REDIR(2),
             .BOOT_DELAY(2), .ALIGN_C(0)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .redir_valid_i(redir_valid),
        .redir_pc_i(redir_pc), .stall_i(stall), .fetch_ready_i(fetch_ready),
        .step_c_i(step_c), .halt_i(halt), .resume_i(resume),
        .pc_o(pc_a), .pc_valid_o(vld_a), .redir_taken_o(taken_a),
        .misalign_o(mis_a), .halted_o(hlt_a));

    pc_gen #(.ADDR_WIDTH(32), .RESET_ADDR(32'h100), .NUM_REDIR(2),
             .BOOT_DELAY(2), .ALIGN_C(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .redir_valid_i(redir_valid),
        .redir_pc_i(redir_pc), .stall_i(stall), .fetch_ready_i(fetch_ready),
        .step_c_i(step_c), .halt_i(halt), .resume_i(resume),
        .pc_o(pc_b), .pc_valid_o(vld_b), .redir_taken_o(taken_b),
        .misalign_o(mis_b), .halted_o(hlt_b));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic redir(input logic [1:0] v, input logic [31:0] ch0, input logic [31:0] ch1);
        redir_valid = v;
        redir_pc    = {ch1, ch0};
    endtask

    initial begin
        rst_i       = 1'b1;
        redir_valid = 2'b00;
        redir_pc    = '0;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        step_c      = 1'b0;
        halt        = 1'b0;
        resume      = 1'b0;

        #2;
        check_val("rst_pc",     pc_a,    32'h100);
        check_val("rst_valid",  vld_a,   0);
        check_val("rst_taken",  taken_a, 0);
        check_val("rst_mis",    mis_a,   0);
        check_val("rst_halted", hlt_a,   0);
        #5 rst_i = 1'b0;

        // Boot sequence
        tick(); check_val("boot_e1_valid", vld_a, 0);
        tick(); check_val("boot_e2_valid", vld_a, 0);
        tick(); check_val("boot_e3_valid", vld_a, 1);
                check_val("boot_e3_pc",    pc_a,  32'h100);
        tick(); check_val("run_pc1", pc_a, 32'h104);
        tick(); check_val("run_pc2", pc_a, 32'h108);

        // Asynchronous reset mid-run, no edge in between
        rst_i = 1'b1;
        #2;
        check_val("async_rst_pc",    pc_a,  32'h100);
        check_val("async_rst_valid", vld_a, 0);
        #3 rst_i = 1'b0;

        // Redirect pulsed during boot becomes the first PC
        redir(2'b10, 32'h0, 32'h3000);
        tick(); check_val("pend_e1_valid", vld_a, 0);
        redir(2'b00, 32'h0, 32'h0);
        tick(); check_val("pend_e2_valid", vld_a, 0);
        tick(); check_val("pend_e3_valid", vld_a, 1);
                check_val("pend_e3_pc",    pc_a,  32'h3000);

        // Stall and handshake
        redir(2'b10, 32'h0, 32'h200);
        tick(); check_val("redir_200", pc_a, 32'h200);
        redir(2'b00, 32'h0, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_val("stall_hold", pc_a, 32'h200);
        end
        stall = 1'b0;
        fetch_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); check_val("notready_hold", pc_a, 32'h200);
        end
        fetch_ready = 1'b1;
        tick(); check_val("release_pc", pc_a, 32'h204);

        // Priority and misalignment
        stall = 1'b1;
        redir(2'b11, 32'h4000, 32'h8000);
        tick(); check_val("prio_pc",    pc_a,    32'h4000);
                check_val("prio_taken", taken_a, 2'b01);
                check_val("prio_mis",   mis_a,   0);
        redir(2'b00, 32'h0, 32'h0);
        tick(); check_val("noredir_taken", taken_a, 0);
                check_val("stall_pc",      pc_a,    32'h4000);
        redir(2'b10, 32'h0, 32'h8003);
        tick(); check_val("mis_pc",    pc_a,    32'h8000);
                check_val("mis_flag",  mis_a,   1);
                check_val("mis_taken", taken_a, 2'b10);
                check_val("mis_pc_b",  pc_b,    32'h8002);
        redir(2'b00, 32'h0, 32'h0);
        tick(); check_val("mis_pulse_end", mis_a, 0);
        stall = 1'b0;

        // Halt / interrupt wake / resume
        redir(2'b10, 32'h0, 32'h500);
        tick(); check_val("halt_setup_pc", pc_a, 32'h500);
        redir(2'b00, 32'h0, 32'h0);
        halt = 1'b1;
        tick(); check_val("halt_halted", hlt_a, 1);
                check_val("halt_valid",  vld_a, 0);
                check_val("halt_pc",     pc_a,  32'h500);
        halt = 1'b0;
        redir(2'b10, 32'h0, 32'h600);
        tick(); check_val("halt_ch1_pc",     pc_a,  32'h600);
                check_val("halt_ch1_halted", hlt_a, 1);
        redir(2'b01, 32'h700, 32'h0);
        tick(); check_val("wake_pc",     pc_a,  32'h700);
                check_val("wake_halted", hlt_a, 0);
                check_val("wake_valid",  vld_a, 1);
        redir(2'b00, 32'h0, 32'h0);
        halt = 1'b1;
        tick(); check_val("halt2_halted", hlt_a, 1);
                check_val("halt2_pc",     pc_a,  32'h700);
        resume = 1'b1;
        tick(); check_val("resume_valid",  vld_a, 1);
                check_val("resume_halted", hlt_a, 0);
                check_val("resume_pc",     pc_a,  32'h700);
        halt = 1'b0;
        resume = 1'b0;

        // Wrap and 2-byte step
        step_c = 1'b1;
        redir(2'b01, 32'hFFFF_FFFE, 32'h0);
        tick(); check_val("wrap_setup_b", pc_b,  32'hFFFF_FFFE);
                check_val("wrap_mis_b",   mis_b, 0);
                check_val("wrap_mis_a",   mis_a, 1);
                check_val("wrap_setup_a", pc_a,  32'hFFFF_FFFC);
        redir(2'b00, 32'h0, 32'h0);
        tick(); check_val("wrap_step2_b", pc_b, 32'h0);
                check_val("wrap_step4_a", pc_a, 32'h0);
        step_c = 1'b0;
        redir(2'b01, 32'hFFFF_FFFC, 32'h0);
        tick(); check_val("wrap4_setup_b", pc_b, 32'hFFFF_FFFC);
        redir(2'b00, 32'h0, 32'h0);
        tick(); check_val("wrap4_b", pc_b, 32'h0);
        tick(); check_val("after_wrap_b", pc_b, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
